// File: rtl/i2c_bus_watchdog_if.sv
// i2c_bus_watchdog_if: monitored bus inputs plus the watchdog's recovery and status outputs
interface i2c_bus_watchdog_if;
  logic       enable;
  logic       sda_out;
  logic       scl;
  logic       clr_status;
  logic       rst_i2c_n;
  logic       busy;
  logic       timeout_flag;
  logic [7:0] timeout_count;
  logic       scl_stuck;
  modport slave (
    input  enable, sda_out, scl, clr_status,
    output rst_i2c_n, busy, timeout_flag, timeout_count, scl_stuck
  );
  modport master (
    output enable, sda_out, scl, clr_status,
    input  rst_i2c_n, busy, timeout_flag, timeout_count, scl_stuck
  );
endinterface

// File: rtl/i2c_bus_watchdog.sv
// i2c_bus_watchdog: recovers a stuck-low slave SDA drive with a timed reset pulse and flags stuck-low SCL
module i2c_bus_watchdog #(
  parameter int TIMEOUT_CYCLES     = 32000,
  parameter int SCL_TIMEOUT_CYCLES = 32000,
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES     = 64,
  parameter int SYNC_STAGES        = 2
) (
  input logic               clk,
  input logic               rst_n,
  i2c_bus_watchdog_if.slave bus
);
  localparam int PH_MAX = RST_PULSE_CYCLES > HOLDOFF_CYCLES ? RST_PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int SW     = $clog2(TIMEOUT_CYCLES);
  localparam int CW     = $clog2(SCL_TIMEOUT_CYCLES);
  localparam int PW     = $clog2(PH_MAX + 1);
  typedef enum logic [1:0] {MONITOR, PULSE, HOLDOFF} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SW-1:0]          r_sda_cnt;
  logic [CW-1:0]          r_scl_cnt;
  logic [PW-1:0]          r_phase;
  logic                   r_rst_i2c_n;
  logic                   r_busy;
  logic                   r_flag;
  logic                   r_scl_stuck;
  logic [7:0]             r_count;
  logic                   w_sda_s;
  logic                   w_scl_s;
  logic                   w_sda_low;
  logic                   w_trip;
  logic                   w_scl_set;
  assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_low = !w_sda_s && bus.enable;
  assign w_trip    = r_state == MONITOR && w_sda_low && r_sda_cnt == SW'(TIMEOUT_CYCLES - 1);
  assign w_scl_set = !w_scl_s && r_scl_cnt == CW'(SCL_TIMEOUT_CYCLES - 1);
  assign bus.rst_i2c_n     = r_rst_i2c_n;
  assign bus.busy          = r_busy;
  assign bus.timeout_flag  = r_flag;
  assign bus.timeout_count = r_count;
  assign bus.scl_stuck     = r_scl_stuck;
  // Synchronisers idle high so reset never looks like a stuck bus
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sda_sync <= '1;
      r_scl_sync <= '1;
    end else begin
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_out};
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl};
    end
  // sda_cnt only advances in MONITOR; it is zeroed on a trip and stays zero through PULSE/HOLDOFF
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= MONITOR;
      r_sda_cnt   <= '0;
      r_phase     <= '0;
      r_rst_i2c_n <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        MONITOR: begin
          r_sda_cnt <= w_sda_low && !w_trip ? r_sda_cnt + 1'b1 : '0;
          if (w_trip) begin
            r_state     <= PULSE;
            r_rst_i2c_n <= 1'b0;
            r_busy      <= 1'b1;
            r_phase     <= '0;
          end
        end
        PULSE:
          if (r_phase == PW'(RST_PULSE_CYCLES - 1)) begin
            r_state     <= HOLDOFF;
            r_rst_i2c_n <= 1'b1;
            r_phase     <= '0;
          end else
            r_phase <= r_phase + 1'b1;
        HOLDOFF:
          if (r_phase == PW'(HOLDOFF_CYCLES - 1)) begin
            r_state <= MONITOR;
            r_busy  <= 1'b0;
            r_phase <= '0;
          end else
            r_phase <= r_phase + 1'b1;
        default: r_state <= MONITOR;
      endcase
    end
  // A trip or SCL set in the same cycle as clr_status wins over the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scl_cnt   <= '0;
      r_flag      <= 1'b0;
      r_count     <= '0;
      r_scl_stuck <= 1'b0;
    end else begin
      r_scl_cnt   <= w_scl_s ? '0 : r_scl_cnt == CW'(SCL_TIMEOUT_CYCLES - 1) ? r_scl_cnt : r_scl_cnt + 1'b1;
      r_flag      <= w_trip | (r_flag & ~bus.clr_status);
      r_scl_stuck <= w_scl_set | (r_scl_stuck & ~bus.clr_status);
      r_count     <= w_trip ? (bus.clr_status ? 8'd1 : r_count + {7'd0, r_count != 8'hFF})
                            : bus.clr_status ? 8'd0 : r_count;
    end
endmodule

// File: tb/tb_i2c_bus_watchdog.sv
// tb_i2c_bus_watchdog: vector table, corner sequences and randomized traffic against a countdown-based reference model
module tb_i2c_bus_watchdog;
  localparam int T = 8, ST = 10, P = 4, H = 6, S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  i2c_bus_watchdog_if bus();
  i2c_bus_watchdog #(
    .TIMEOUT_CYCLES(T), .SCL_TIMEOUT_CYCLES(ST), .RST_PULSE_CYCLES(P),
    .HOLDOFF_CYCLES(H), .SYNC_STAGES(S)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit en, sda, scl, clr;
    int n;
    bit rst, busy, flag;
    int cnt;
    bit stk;
  } vec_t;
  vec_t tbl[18];
  // Model: inputs seen through an S-deep delay line; recovery is a single countdown of P+H cycles
  logic [S-1:0] sda_h, scl_h;
  int lowrun, left, sclrun, m_cnt;
  bit m_flag, m_scl;
  function automatic vec_t vec(int en, int sda, int scl, int clr, int n, int rst, int busy, int flag, int cnt, int stk);
    vec_t v;
    v.en = en != 0; v.sda = sda != 0; v.scl = scl != 0; v.clr = clr != 0; v.n = n;
    v.rst = rst != 0; v.busy = busy != 0; v.flag = flag != 0; v.cnt = cnt; v.stk = stk != 0;
    return v;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    sda_h = '1; scl_h = '1;
    lowrun = 0; left = 0; sclrun = 0; m_cnt = 0; m_flag = 0; m_scl = 0;
  endtask
  task automatic model_step(input bit en, input bit sda, input bit scl, input bit clr);
    bit s_sda, s_scl, trip;
    s_sda = sda_h[S-1]; s_scl = scl_h[S-1]; trip = 0;
    sda_h = {sda_h[S-2:0], sda};
    scl_h = {scl_h[S-2:0], scl};
    if (left > 0) begin
      left--;
      lowrun = 0;
    end else if (!s_sda && en) begin
      lowrun++;
      if (lowrun == T) begin
        trip = 1; left = P + H; lowrun = 0;
      end
    end else
      lowrun = 0;
    sclrun = s_scl ? 0 : sclrun + 1;
    if (clr) begin
      m_flag = 0; m_cnt = 0; m_scl = 0;
    end
    if (trip) begin
      m_flag = 1; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
    end
    if (sclrun >= ST) m_scl = 1;
  endtask
  task automatic compare_all(input string tag);
    chk({tag, ".rst_i2c_n"}, int'(bus.rst_i2c_n), int'(!(left > H)));
    chk({tag, ".busy"}, int'(bus.busy), int'(left > 0));
    chk({tag, ".flag"}, int'(bus.timeout_flag), int'(m_flag));
    chk({tag, ".count"}, int'(bus.timeout_count), m_cnt);
    chk({tag, ".scl_stuck"}, int'(bus.scl_stuck), int'(m_scl));
  endtask
  task automatic cyc(input bit en, input bit sda, input bit scl, input bit clr);
    bus.enable = en; bus.sda_out = sda; bus.scl = scl; bus.clr_status = clr;
    @(posedge clk);
    model_step(en, sda, scl, clr);
    #1;
    compare_all("model");
  endtask
  initial begin
    int lows;
    bit r_en, r_sda, r_scl;
    tbl[0]  = vec(1, 1, 1, 0, 5,  1, 0, 0, 0, 0);
    tbl[1]  = vec(1, 0, 1, 0, 7,  1, 0, 0, 0, 0);
    tbl[2]  = vec(1, 1, 1, 0, 5,  1, 0, 0, 0, 0);
    tbl[3]  = vec(1, 0, 1, 0, 10, 0, 1, 1, 1, 0);
    tbl[4]  = vec(1, 0, 1, 0, 3,  0, 1, 1, 1, 0);
    tbl[5]  = vec(1, 0, 1, 0, 1,  1, 1, 1, 1, 0);
    tbl[6]  = vec(1, 0, 1, 0, 5,  1, 1, 1, 1, 0);
    tbl[7]  = vec(1, 0, 1, 0, 1,  1, 0, 1, 1, 0);
    tbl[8]  = vec(1, 0, 1, 0, 7,  1, 0, 1, 1, 0);
    tbl[9]  = vec(1, 0, 1, 0, 1,  0, 1, 1, 2, 0);
    tbl[10] = vec(1, 1, 0, 0, 11, 1, 0, 1, 2, 0);
    tbl[11] = vec(1, 1, 0, 0, 1,  1, 0, 1, 2, 1);
    tbl[12] = vec(1, 1, 0, 1, 1,  1, 0, 0, 0, 1);
    tbl[13] = vec(1, 1, 1, 0, 3,  1, 0, 0, 0, 1);
    tbl[14] = vec(1, 1, 1, 1, 1,  1, 0, 0, 0, 0);
    tbl[15] = vec(0, 0, 1, 0, 20, 1, 0, 0, 0, 0);
    tbl[16] = vec(1, 0, 1, 0, 7,  1, 0, 0, 0, 0);
    tbl[17] = vec(1, 0, 1, 1, 1,  0, 1, 1, 1, 0);
    bus.enable = 1; bus.sda_out = 1; bus.scl = 1; bus.clr_status = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1;
    for (int i = 0; i < 18; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].en, tbl[i].sda, tbl[i].scl, tbl[i].clr);
      chk($sformatf("vec%0d.rst_i2c_n", i), int'(bus.rst_i2c_n), int'(tbl[i].rst));
      chk($sformatf("vec%0d.busy", i), int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d.flag", i), int'(bus.timeout_flag), int'(tbl[i].flag));
      chk($sformatf("vec%0d.count", i), int'(bus.timeout_count), tbl[i].cnt);
      chk($sformatf("vec%0d.scl_stuck", i), int'(bus.scl_stuck), int'(tbl[i].stk));
    end
    // enable drops two clocks into the pulse; the pulse length must not change
    lows = 1;
    for (int k = 0; k < 12; k++) begin
      cyc(k == 0, 0, 1, 0);
      lows += int'(!bus.rst_i2c_n);
    end
    chk("pulse_len_enable_drop", lows, P);
    chk("busy_after_recovery", int'(bus.busy), 0);
    repeat (30) cyc(0, 0, 1, 0);
    chk("disabled_no_trip.count", int'(bus.timeout_count), 1);
    chk("disabled_no_trip.rst_i2c_n", int'(bus.rst_i2c_n), 1);
    // saturation: fresh reset, then SDA stuck for 301 trips ending on a trip edge
    rst_n = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10 + 18 * 300) cyc(1, 0, 1, 0);
    chk("sat.count", int'(bus.timeout_count), 255);
    chk("sat.flag", int'(bus.timeout_flag), 1);
    chk("sat.rst_i2c_n", int'(bus.rst_i2c_n), 0);
    cyc(1, 0, 1, 1);
    chk("sat_clr.count", int'(bus.timeout_count), 0);
    chk("sat_clr.flag", int'(bus.timeout_flag), 0);
    cyc(1, 0, 1, 0);
    chk("pre_async.rst_i2c_n", int'(bus.rst_i2c_n), 0);
    // async reset mid-pulse, checked with no clock edge in between
    #2;
    rst_n = 0;
    #1;
    chk("async.rst_i2c_n", int'(bus.rst_i2c_n), 1);
    chk("async.busy", int'(bus.busy), 0);
    chk("async.flag", int'(bus.timeout_flag), 0);
    chk("async.count", int'(bus.timeout_count), 0);
    chk("async.scl_stuck", int'(bus.scl_stuck), 0);
    bus.sda_out = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) cyc(1, 1, 1, 0);
    r_en = 1; r_sda = 1; r_scl = 1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(15) == 0) r_sda = ~r_sda;
      if ($urandom_range(11) == 0) r_scl = ~r_scl;
      if ($urandom_range(49) == 0) r_en = ~r_en;
      cyc(r_en, r_sda, r_scl, $urandom_range(39) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
